// File: rtl/pipeline_stall_ctrl_if.sv
// Control bundle between the hazard/branch/memory sources and pipeline_stall_ctrl.
// The master side produces the hazard inputs; the slave side is the stall controller.
`timescale 1ns/1ps

interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             load_use_i;
    logic             branch_taken_i;
    logic             mem_access_i;
    logic             mem_ack_i;
    logic             mem_req_o;
    logic             pc_write_o;
    logic             if_id_write_o;
    logic             if_id_flush_o;
    logic             id_ex_bubble_o;
    logic             back_write_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output load_use_i,
        output branch_taken_i,
        output mem_access_i,
        output mem_ack_i,
        input  mem_req_o,
        input  pc_write_o,
        input  if_id_write_o,
        input  if_id_flush_o,
        input  id_ex_bubble_o,
        input  back_write_o,
        input  err_o,
        input  stall_cnt_o,
        input  flush_cnt_o
    );

    modport slave (
        input  load_use_i,
        input  branch_taken_i,
        input  mem_access_i,
        input  mem_ack_i,
        output mem_req_o,
        output pc_write_o,
        output if_id_write_o,
        output if_id_flush_o,
        output id_ex_bubble_o,
        output back_write_o,
        output err_o,
        output stall_cnt_o,
        output flush_cnt_o
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, data-memory freeze.
// Optional performance counters are built only when PIPELINE_STALL_CTRL_PERF_CNT_EN is defined.
`timescale 1ns/1ps

module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pipeline_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_RESUME   = 2'd2
    } state_e;

    localparam int                WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit                TIMEOUT_EN = (MEM_TIMEOUT != 0);
    // Counter parks at the timeout value; with the timeout disabled it never leaves zero.
    localparam logic [WAIT_W-1:0] WAIT_CAP   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q;
    state_e            state_d;
    logic              mem_req_q;
    logic              mem_req_d;
    logic              err_q;
    logic              err_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;

    logic              hz_pc_write_s;
    logic              hz_if_id_write_s;
    logic              hz_flush_s;
    logic              hz_bubble_s;
    logic              freeze_s;
    logic              pc_write_s;
    logic              if_id_write_s;
    logic              if_id_flush_s;
    logic              id_ex_bubble_s;
    logic              back_write_s;

    // Hazard arbitration: load-use outranks branch flush because branch operands are not ready yet.
    always_comb begin
        hz_pc_write_s    = 1'b1;
        hz_if_id_write_s = 1'b1;
        hz_flush_s       = 1'b0;
        hz_bubble_s      = 1'b0;
        if (bus.load_use_i) begin
            hz_pc_write_s    = 1'b0;
            hz_if_id_write_s = 1'b0;
            hz_bubble_s      = 1'b1;
        end else if (bus.branch_taken_i) begin
            hz_flush_s       = 1'b1;
        end else begin
            hz_pc_write_s    = 1'b1;
            hz_if_id_write_s = 1'b1;
        end
    end

    // Next-state logic and per-stage enables; a freeze overrides every hazard action.
    always_comb begin
        state_d        = state_q;
        freeze_s       = 1'b0;
        pc_write_s     = 1'b1;
        if_id_write_s  = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_bubble_s = 1'b0;
        back_write_s   = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (bus.mem_access_i) begin
                    freeze_s = 1'b1;
                    state_d  = ST_MEM_WAIT;
                end else begin
                    freeze_s = 1'b0;
                    state_d  = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                freeze_s = 1'b1;
                if (bus.mem_ack_i) begin
                    state_d = ST_RESUME;
                end else begin
                    state_d = ST_MEM_WAIT;
                end
            end
            // The served instruction is still in MEM here, so its access request is ignored.
            ST_RESUME: begin
                freeze_s = 1'b0;
                state_d  = ST_RUN;
            end
            default: begin
                freeze_s = 1'b1;
                state_d  = ST_RUN;
            end
        endcase
        if (freeze_s) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            if_id_flush_s  = 1'b0;
            id_ex_bubble_s = 1'b0;
            back_write_s   = 1'b0;
        end else begin
            pc_write_s     = hz_pc_write_s;
            if_id_write_s  = hz_if_id_write_s;
            if_id_flush_s  = hz_flush_s;
            id_ex_bubble_s = hz_bubble_s;
            back_write_s   = 1'b1;
        end
    end

    // Wait counter, sticky timeout flag and registered memory request.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        mem_req_d  = (state_d == ST_MEM_WAIT);
        if ((state_q == ST_RUN) && bus.mem_access_i) begin
            wait_cnt_d = {WAIT_W{1'b0}};
        end else if ((state_q == ST_MEM_WAIT) && !bus.mem_ack_i) begin
            if (wait_cnt_q != WAIT_CAP) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1'b1);
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
            if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            mem_req_q  <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt_q <= {WAIT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.mem_req_o      = mem_req_q;
    assign bus.err_o          = err_q;
    assign bus.pc_write_o     = pc_write_s;
    assign bus.if_id_write_o  = if_id_write_s;
    assign bus.if_id_flush_o  = if_id_flush_s;
    assign bus.id_ex_bubble_o = id_ex_bubble_s;
    assign bus.back_write_o   = back_write_s;

`ifdef PIPELINE_STALL_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    // Stall cycles are those where the PC holds; flush cycles are those that squash IF/ID.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write_s) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (if_id_flush_s) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;
`else
    assign bus.stall_cnt_o = {CNT_W{1'b0}};
    assign bus.flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl (MEM_TIMEOUT=4); counter checks follow PIPELINE_STALL_CTRL_PERF_CNT_EN.
`timescale 1ns/1ps

module tb_pipeline_stall_ctrl;

    localparam int CNT_W = 16;
`ifdef PIPELINE_STALL_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Output vector order: {mem_req, pc_write, if_id_write, flush, bubble, back_write, err}
    localparam logic [6:0] V_RUN  = 7'b0110010;
    localparam logic [6:0] V_FRZ  = 7'b0000000;
    localparam logic [6:0] V_WAIT = 7'b1000000;
    localparam logic [6:0] V_LU   = 7'b0000110;
    localparam logic [6:0] V_BR   = 7'b0111010;
    localparam logic [6:0] E      = 7'b0000001;

    typedef struct packed {
        logic [6:0]       vec;
        logic [CNT_W-1:0] st;
        logic [CNT_W-1:0] fl;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    int   total;
    int   bad;
    int   stall_m;
    int   flush_m;

    pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] cnt_exp(input int v);
        return PERF ? CNT_W'(v) : {CNT_W{1'b0}};
    endfunction

    function automatic logic [6:0] outs();
        return {bus.mem_req_o, bus.pc_write_o, bus.if_id_write_o, bus.if_id_flush_o,
                bus.id_ex_bubble_o, bus.back_write_o, bus.err_o};
    endfunction

    // Scoreboard push: counters shown this cycle reflect earlier cycles only.
    task automatic push_exp(input logic [6:0] v, input bit in_rst);
        exp_t e;
        e.vec = v;
        e.st  = cnt_exp(stall_m);
        e.fl  = cnt_exp(flush_m);
        sb_q.push_back(e);
        if (!in_rst) begin
            if (!v[5]) stall_m++;
            if (v[3])  flush_m++;
        end
    endtask

    // stim = {load_use, branch_taken, mem_access, mem_ack}
    task automatic drive(input logic [3:0] stim);
        @(posedge clk);
        #1;
        bus.load_use_i     = stim[3];
        bus.branch_taken_i = stim[2];
        bus.mem_access_i   = stim[1];
        bus.mem_ack_i      = stim[0];
    endtask

    task automatic test_reset();
        exp_t       e;
        logic [6:0] got;
        rst = 1'b1;
        drive(4'b0000);
        stall_m = 0;
        flush_m = 0;
        push_exp(V_RUN, 1'b1);
        @(negedge clk);
        got = outs();
        e   = sb_q.pop_front();
        total++;
        if (got !== e.vec) begin
            bad++;
            $display("FAIL reset outputs: got %b want %b", got, e.vec);
        end
        total++;
        if (bus.stall_cnt_o !== e.st || bus.flush_cnt_o !== e.fl) begin
            bad++;
            $display("FAIL reset counters: got %0d/%0d want %0d/%0d", bus.stall_cnt_o, bus.flush_cnt_o, e.st, e.fl);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        logic [3:0] st [3] = '{4'b1000, 4'b0000, 4'b0000};
        logic [6:0] ev [3] = '{V_LU, V_RUN, V_RUN};
        exp_t       e;
        logic [6:0] got;
        for (int i = 0; i < 3; i++) begin
            drive(st[i]);
            push_exp(ev[i], 1'b0);
            @(negedge clk);
            got = outs();
            e   = sb_q.pop_front();
            total++;
            if (got !== e.vec) begin
                bad++;
                $display("FAIL load_use[%0d] outputs: got %b want %b", i, got, e.vec);
            end
            total++;
            if (bus.stall_cnt_o !== e.st || bus.flush_cnt_o !== e.fl) begin
                bad++;
                $display("FAIL load_use[%0d] counters: got %0d/%0d want %0d/%0d", i, bus.stall_cnt_o, bus.flush_cnt_o, e.st, e.fl);
            end
        end
    endtask

    task automatic test_lu_branch();
        logic [3:0] st [3] = '{4'b1100, 4'b0100, 4'b0000};
        logic [6:0] ev [3] = '{V_LU, V_BR, V_RUN};
        exp_t       e;
        logic [6:0] got;
        for (int i = 0; i < 3; i++) begin
            drive(st[i]);
            push_exp(ev[i], 1'b0);
            @(negedge clk);
            got = outs();
            e   = sb_q.pop_front();
            total++;
            if (got !== e.vec) begin
                bad++;
                $display("FAIL lu_branch[%0d] outputs: got %b want %b", i, got, e.vec);
            end
            total++;
            if (bus.stall_cnt_o !== e.st || bus.flush_cnt_o !== e.fl) begin
                bad++;
                $display("FAIL lu_branch[%0d] counters: got %0d/%0d want %0d/%0d", i, bus.stall_cnt_o, bus.flush_cnt_o, e.st, e.fl);
            end
        end
    endtask

    task automatic test_mem_wait3();
        logic [3:0] st [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0011, 4'b0000};
        logic [6:0] ev [6] = '{V_FRZ, V_WAIT, V_WAIT, V_WAIT, V_RUN, V_RUN};
        exp_t       e;
        logic [6:0] got;
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            push_exp(ev[i], 1'b0);
            @(negedge clk);
            got = outs();
            e   = sb_q.pop_front();
            total++;
            if (got !== e.vec) begin
                bad++;
                $display("FAIL mem_wait3[%0d] outputs: got %b want %b", i, got, e.vec);
            end
            total++;
            if (bus.stall_cnt_o !== e.st || bus.flush_cnt_o !== e.fl) begin
                bad++;
                $display("FAIL mem_wait3[%0d] counters: got %0d/%0d want %0d/%0d", i, bus.stall_cnt_o, bus.flush_cnt_o, e.st, e.fl);
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] st [10] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                4'b0010, 4'b0010, 4'b0011, 4'b0000, 4'b0000};
        logic [6:0] ev [10] = '{V_FRZ, V_WAIT, V_WAIT, V_WAIT, V_WAIT,
                                V_WAIT | E, V_WAIT | E, V_WAIT | E, V_RUN | E, V_RUN | E};
        exp_t       e;
        logic [6:0] got;
        for (int i = 0; i < 10; i++) begin
            drive(st[i]);
            push_exp(ev[i], 1'b0);
            @(negedge clk);
            got = outs();
            e   = sb_q.pop_front();
            total++;
            if (got !== e.vec) begin
                bad++;
                $display("FAIL timeout[%0d] outputs: got %b want %b", i, got, e.vec);
            end
            total++;
            if (bus.stall_cnt_o !== e.st || bus.flush_cnt_o !== e.fl) begin
                bad++;
                $display("FAIL timeout[%0d] counters: got %0d/%0d want %0d/%0d", i, bus.stall_cnt_o, bus.flush_cnt_o, e.st, e.fl);
            end
        end
    endtask

    task automatic test_spurious();
        logic [3:0] st [5] = '{4'b0001, 4'b1110, 4'b0001, 4'b1100, 4'b0000};
        logic [6:0] ev [5] = '{V_RUN | E, V_FRZ | E, V_WAIT | E, V_LU | E, V_RUN | E};
        exp_t       e;
        logic [6:0] got;
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            push_exp(ev[i], 1'b0);
            @(negedge clk);
            got = outs();
            e   = sb_q.pop_front();
            total++;
            if (got !== e.vec) begin
                bad++;
                $display("FAIL spurious[%0d] outputs: got %b want %b", i, got, e.vec);
            end
            total++;
            if (bus.stall_cnt_o !== e.st || bus.flush_cnt_o !== e.fl) begin
                bad++;
                $display("FAIL spurious[%0d] counters: got %0d/%0d want %0d/%0d", i, bus.stall_cnt_o, bus.flush_cnt_o, e.st, e.fl);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [3:0] st [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
        logic [6:0] ev [4] = '{V_FRZ | E, V_WAIT | E, V_RUN, V_RUN};
        exp_t       e;
        logic [6:0] got;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                // Release reset (asserted mid-cycle below) just after an edge.
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            drive(st[i]);
            push_exp(ev[i], 1'b0);
            @(negedge clk);
            got = outs();
            e   = sb_q.pop_front();
            total++;
            if (got !== e.vec) begin
                bad++;
                $display("FAIL reset_mid_wait[%0d] outputs: got %b want %b", i, got, e.vec);
            end
            total++;
            if (bus.stall_cnt_o !== e.st || bus.flush_cnt_o !== e.fl) begin
                bad++;
                $display("FAIL reset_mid_wait[%0d] counters: got %0d/%0d want %0d/%0d", i, bus.stall_cnt_o, bus.flush_cnt_o, e.st, e.fl);
            end
            if (i == 1) begin
                #2;
                rst                = 1'b1;
                bus.load_use_i     = 1'b0;
                bus.branch_taken_i = 1'b0;
                bus.mem_access_i   = 1'b0;
                bus.mem_ack_i      = 1'b0;
                stall_m            = 0;
                flush_m            = 0;
                push_exp(V_RUN, 1'b1);
                #1;
                got = outs();
                e   = sb_q.pop_front();
                total++;
                if (got !== e.vec) begin
                    bad++;
                    $display("FAIL async_reset outputs: got %b want %b", got, e.vec);
                end
                total++;
                if (bus.stall_cnt_o !== e.st || bus.flush_cnt_o !== e.fl) begin
                    bad++;
                    $display("FAIL async_reset counters: got %0d/%0d want %0d/%0d", bus.stall_cnt_o, bus.flush_cnt_o, e.st, e.fl);
                end
            end
        end
    endtask

    initial begin
        total              = 0;
        bad                = 0;
        stall_m            = 0;
        flush_m            = 0;
        rst                = 1'b1;
        bus.load_use_i     = 1'b0;
        bus.branch_taken_i = 1'b0;
        bus.mem_access_i   = 1'b0;
        bus.mem_ack_i      = 1'b0;
        test_reset();
        test_load_use();
        test_lu_branch();
        test_mem_wait3();
        test_timeout();
        test_spurious();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
